// File: rtl/reg_rename_stage.sv
// Register-rename stage: translates architectural rs/rt/rw through a
// speculative map table, allocates destinations from a FIFO free list,
// tracks per-physical-register busy bits and holds the result in a
// single output register with valid/ready handshaking.
module reg_rename_stage #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_REGS  = 64,
  parameter int FREE_DEPTH = PHYS_REGS - ARCH_REGS,
  parameter int AW         = $clog2(ARCH_REGS),
  parameter int PW         = $clog2(PHYS_REGS),
  parameter int FPW        = $clog2(FREE_DEPTH),
  parameter int CW         = $clog2(FREE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_uses_rs,
  input  logic          in_uses_rt,
  input  logic          in_uses_rw,
  input  logic [AW-1:0] in_rs_addr,
  input  logic [AW-1:0] in_rt_addr,
  input  logic [AW-1:0] in_rw_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_uses_rs,
  output logic          out_uses_rt,
  output logic          out_uses_rw,
  output logic [PW-1:0] out_rs_phys,
  output logic [PW-1:0] out_rt_phys,
  output logic [PW-1:0] out_rw_phys,
  output logic [PW-1:0] out_rw_old_phys,
  output logic          out_rs_busy,
  output logic          out_rt_busy,
  input  logic          wb_valid,
  input  logic [PW-1:0] wb_phys,
  input  logic          commit_valid,
  input  logic [PW-1:0] commit_old_phys,
  output logic [CW-1:0] free_count,
  output logic          err
);

  logic [PW-1:0]        map_q  [ARCH_REGS];
  logic [PW-1:0]        free_q [FREE_DEPTH];
  logic [PHYS_REGS-1:0] busy_q;
  logic [PHYS_REGS-1:0] busy_d;
  logic [FPW-1:0]       head_q;
  logic [FPW-1:0]       tail_q;

  logic          accept;
  logic          eff_rw;
  logic          pop;
  logic          push;
  logic          push_bad;
  logic [PW-1:0] rs_phys;
  logic [PW-1:0] rt_phys;
  logic          rs_busy;
  logic          rt_busy;
  logic [PW-1:0] new_phys;
  logic [PW-1:0] old_phys;

  // Handshake: conservative stall on an empty free list even without rw.
  assign in_ready = (!out_valid || out_ready) && (free_count != '0);
  assign accept   = in_valid && in_ready;
  assign eff_rw   = in_uses_rw && (in_rw_addr != '0);
  assign pop      = accept && eff_rw;
  assign push_bad = commit_valid &&
                    ((commit_old_phys == '0) || (free_count == CW'(FREE_DEPTH)));
  assign push     = commit_valid && !push_bad;
  assign new_phys = free_q[head_q];
  assign old_phys = map_q[in_rw_addr];

  // Source lookup against the pre-update map, with same-cycle write-back bypass.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rs_phys = '0;
    rt_phys = '0;
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (in_uses_rs) begin
      rs_phys = map_q[in_rs_addr];
      rs_busy = busy_q[rs_phys] && !(wb_valid && (wb_phys == rs_phys));
    end
    if (in_uses_rt) begin
      rt_phys = map_q[in_rt_addr];
      rt_busy = busy_q[rt_phys] && !(wb_valid && (wb_phys == rt_phys));
    end
  end

  // Busy next state: write-back clears, allocation sets and wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_phys] = 1'b0;
    if (pop)      busy_d[new_phys] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Map table, free-list FIFO, busy bits, count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: map and free list are small flop arrays whose reset contents are
      // architecturally visible (identity map, ascending free list), so they
      // are reset explicitly rather than left as uninitialised RAM.
      for (int i = 0; i < ARCH_REGS; i++)  map_q[i]  <= PW'(i);
      for (int i = 0; i < FREE_DEPTH; i++) free_q[i] <= PW'(ARCH_REGS + i);
      busy_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      free_count <= CW'(FREE_DEPTH);
      err        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read in
      // this edge sees the pre-edge values (pushed entry not poppable this cycle).
      if (pop) begin
        map_q[in_rw_addr] <= new_phys;
        head_q            <= head_q + 1'b1;
      end
      if (push) begin
        free_q[tail_q] <= commit_old_phys;
        tail_q         <= tail_q + 1'b1;
      end
      busy_q     <= busy_d;
      free_count <= free_count + CW'(push) - CW'(pop);
      if (push_bad) err <= 1'b1;
    end
  end

  // Output register: load on accept, drain on ready, refresh busy flags while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_uses_rs     <= 1'b0;
      out_uses_rt     <= 1'b0;
      out_uses_rw     <= 1'b0;
      out_rs_phys     <= '0;
      out_rt_phys     <= '0;
      out_rw_phys     <= '0;
      out_rw_old_phys <= '0;
      out_rs_busy     <= 1'b0;
      out_rt_busy     <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_uses_rs     <= in_uses_rs;
      out_uses_rt     <= in_uses_rt;
      out_uses_rw     <= eff_rw;
      out_rs_phys     <= rs_phys;
      out_rt_phys     <= rt_phys;
      out_rw_phys     <= eff_rw ? new_phys : '0;
      out_rw_old_phys <= eff_rw ? old_phys : '0;
      out_rs_busy     <= rs_busy;
      out_rt_busy     <= rt_busy;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (wb_valid && (wb_phys == out_rs_phys)) out_rs_busy <= 1'b0;
      if (wb_valid && (wb_phys == out_rt_phys)) out_rt_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_rename_stage.sv
// Scoreboard bench for reg_rename_stage: the driver pushes hand-computed
// expected outputs at acceptance, a monitor pops and compares on each transfer.
module tb_reg_rename_stage;

  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic       uses_rw;
    logic [5:0] rs_phys;
    logic [5:0] rt_phys;
    logic [5:0] rw_phys;
    logic [5:0] rw_old;
    logic       rs_busy;
    logic       rt_busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_uses_rs = 1'b0, in_uses_rt = 1'b0, in_uses_rw = 1'b0;
  logic [4:0] in_rs_addr = '0, in_rt_addr = '0, in_rw_addr = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_uses_rs, out_uses_rt, out_uses_rw;
  logic [5:0] out_rs_phys, out_rt_phys, out_rw_phys, out_rw_old_phys;
  logic       out_rs_busy, out_rt_busy;
  logic       wb_valid = 1'b0;
  logic [5:0] wb_phys = '0;
  logic       commit_valid = 1'b0;
  logic [5:0] commit_old_phys = '0;
  logic [5:0] free_count;
  logic       err;

  int checks = 0;
  int errors = 0;
  out_t  sb_q[$];
  string name_q[$];

  reg_rename_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
    .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys),
    .out_rw_phys(out_rw_phys), .out_rw_old_phys(out_rw_old_phys),
    .out_rs_busy(out_rs_busy), .out_rt_busy(out_rt_busy),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .commit_valid(commit_valid), .commit_old_phys(commit_old_phys),
    .free_count(free_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic out_t mk(input logic urs, input logic urt, input logic urw,
                              input logic [5:0] rsp, input logic [5:0] rtp,
                              input logic [5:0] rwp, input logic [5:0] old,
                              input logic rsb, input logic rtb);
    out_t o;
    o.uses_rs = urs; o.uses_rt = urt; o.uses_rw = urw;
    o.rs_phys = rsp; o.rt_phys = rtp; o.rw_phys = rwp; o.rw_old = old;
    o.rs_busy = rsb; o.rt_busy = rtb;
    return o;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; push its expected output when it is about to be accepted.
  task automatic issue(input logic urs, input logic urt, input logic urw,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                       input out_t exp, input string name);
    int n;
    in_valid = 1'b1;
    in_uses_rs = urs; in_uses_rt = urt; in_uses_rw = urw;
    in_rs_addr = rs;  in_rt_addr = rt;  in_rw_addr = rw;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 60);
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    name_q.push_back(name);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: one comparison per output transfer.
  initial begin
    out_t act;
    string nm;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        act = {out_uses_rs, out_uses_rt, out_uses_rw, out_rs_phys, out_rt_phys,
               out_rw_phys, out_rw_old_phys, out_rs_busy, out_rt_busy};
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(act), 64'd0);
        end else begin
          nm = name_q.pop_front();
          check(nm, 64'(act), 64'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int rw;
    logic [5:0] old;
    int n;

    // Reset state
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_free_count", 64'(free_count), 64'd32);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_out_rw_phys", 64'(out_rw_phys), 64'd0);
    step();

    // First instruction and back-to-back dependency with write-back bypass
    issue(1, 1, 1, 5'd3, 5'd4, 5'd5, mk(1, 1, 1, 6'd3, 6'd4, 6'd32, 6'd5, 0, 0), "first");
    issue(1, 0, 1, 5'd5, 5'd9, 5'd5, mk(1, 0, 1, 6'd32, 6'd0, 6'd33, 6'd32, 1, 0), "dep_busy");
    wb_valid = 1'b1; wb_phys = 6'd33;
    issue(1, 0, 1, 5'd5, 5'd9, 5'd5, mk(1, 0, 1, 6'd33, 6'd0, 6'd34, 6'd33, 0, 0), "dep_bypass");
    wb_valid = 1'b0;
    @(negedge clk);
    check("count_after_three", 64'(free_count), 64'd29);
    step();

    // rw=6..11 take phys 35..40
    for (int i = 0; i < 6; i++)
      issue(0, 0, 1, 5'd0, 5'd0, 5'(6 + i),
            mk(0, 0, 1, 6'd0, 6'd0, 6'(35 + i), 6'(6 + i), 0, 0), "alloc_6_11");
    step();

    // Hold an instruction whose rt (arch 11 -> phys 40) is busy, then write back 40
    out_ready = 1'b0;
    issue(1, 1, 0, 5'd1, 5'd11, 5'd0, mk(1, 1, 0, 6'd1, 6'd40, 6'd0, 6'd0, 0, 0), "held_drained");
    @(negedge clk);
    check("held_valid", 64'(out_valid), 64'd1);
    check("held_rt_busy_before", 64'(out_rt_busy), 64'd1);
    check("held_in_ready", 64'(in_ready), 64'd0);
    step();
    wb_valid = 1'b1; wb_phys = 6'd40;
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("held_rt_busy_after", 64'(out_rt_busy), 64'd0);
    check("held_rt_phys", 64'(out_rt_phys), 64'd40);
    check("held_rs_phys", 64'(out_rs_phys), 64'd1);
    check("held_still_valid", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b1;
    step();

    // Commit of phys 0 sets err and leaves the count alone
    commit_valid = 1'b1; commit_old_phys = 6'd0;
    step();
    commit_valid = 1'b0;
    @(negedge clk);
    check("commit0_err", 64'(err), 64'd1);
    check("commit0_count", 64'(free_count), 64'd23);
    step();

    // Mid-stream reset discards a held output and restores everything
    out_ready = 1'b0;
    issue(1, 1, 1, 5'd1, 5'd2, 5'd3, mk(1, 1, 1, 6'd1, 6'd2, 6'd41, 6'd3, 0, 0), "discarded");
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    name_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(free_count), 64'd32);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_rw_phys", 64'(out_rw_phys), 64'd0);
    check("mid_rst_rt_phys", 64'(out_rt_phys), 64'd0);
    step();
    issue(1, 1, 1, 5'd5, 5'd11, 5'd5, mk(1, 1, 1, 6'd5, 6'd11, 6'd32, 6'd5, 0, 0), "post_rst_map");
    step();

    // Exhaust the free list: 32 allocations in order
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rw  = (i % 31) + 1;
      old = (i == 31) ? 6'd32 : 6'(rw);
      issue(0, 0, 1, 5'd0, 5'd0, 5'(rw), mk(0, 0, 1, 6'd0, 6'd0, 6'(32 + i), old, 0, 0), "fill");
    end
    @(negedge clk);
    check("empty_count", 64'(free_count), 64'd0);
    check("empty_in_ready", 64'(in_ready), 64'd0);
    step();

    // 33rd instruction stalls until phys 7 is committed, then receives it
    fork
      issue(1, 0, 1, 5'd2, 5'd0, 5'd2, mk(1, 0, 1, 6'd33, 6'd0, 6'd7, 6'd33, 1, 0), "stalled_gets_7");
      begin
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        step();
        commit_valid = 1'b1; commit_old_phys = 6'd7;
        step();
        commit_valid = 1'b0;
        @(negedge clk);
        check("after_commit_in_ready", 64'(in_ready), 64'd1);
      end
    join
    @(negedge clk);
    check("refill_used_count", 64'(free_count), 64'd0);
    step();

    // Commit into a full free list is dropped and err sticks
    rst = 1'b1;
    step();
    rst = 1'b0;
    commit_valid = 1'b1; commit_old_phys = 6'd40;
    step();
    commit_valid = 1'b0;
    @(negedge clk);
    check("overflow_err", 64'(err), 64'd1);
    check("overflow_count", 64'(free_count), 64'd32);
    repeat (2) step();
    @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);

    // Drain scoreboard with a bounded wait
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
